qpu_exu_oitf_gen: RTL and testbench
===================================

// Module: qpu_exu_oitf_gen
// PURPOSE
//  Parametrised outstanding-instruction tracker for the EXU, successor to the fixed-depth OITF.
//  Two independent circular FIFOs: CL tracks long-pipe classical writebacks (rdidx),
//  MF tracks in-flight measurements (qubit lists). Provides RAW/WAW hazard matches to dispatch,
//  retire order, occupancy counts, pipeline flush and sticky underflow error (absent in v1).
// PARAMETERS
//  CL_DEPTH   4  CL FIFO entries, >=2, any integer; non power-of-two allowed
//  MF_DEPTH   4  MF FIFO entries, >=2, any integer; non power-of-two allowed
//  RFIDX_W    5  register index width (`QPU_RFIDX_REAL_WIDTH)
//  QUBIT_NUM  8  qubit list width (`QPU_QUBIT_NUM)
// PORTS
//  clk                   in   1            clock
//  rst_n                 in   1            async active-low reset
//  flush                 in   1            drop all CL and MF entries
//  dis_cl_ena            in   1            allocate CL entry
//  dis_cl_ready          out  1            CL not full
//  disp_i_rdwen          in   1            entry writes rd
//  disp_i_rdidx          in   RFIDX_W      rd index
//  disp_i_rs1en/rs2en    in   1            source enables, for match
//  disp_i_rs1idx/rs2idx  in   RFIDX_W      source indices, for match
//  dis_qf_ena            in   1            allocate MF entry
//  dis_mf_ready          out  1            MF not full
//  disp_i_qfren          in   1            dispatched instr uses qubit flags
//  disp_i_ql             in   QUBIT_NUM    qubit list (match and MF allocation data)
//  ret_cl_ena            in   1            retire CL head
//  ret_qf_ena            in   1            retire MF head
//  ret_rdidx             out  RFIDX_W      CL head rdidx
//  ret_rdwen             out  1            CL head rdwen
//  ret_mf                out  QUBIT_NUM    MF head qubit list
//  oitfrd_match_disprs1  out  1            valid CL entry, rdwen && rd==rs1 && rs1en
//  oitfrd_match_disprs2  out  1            as above for rs2
//  oitfrd_match_disprd   out  1            valid CL entry, rdwen && rd==disp rd && disp rdwen
//  oitfqf_match_dispql   out  1            qfren && |(OR of valid MF lists & disp_i_ql)
//  oitf_empty/moitf_empty out 1            CL/MF empty
//  cl_count              out  $clog2(CL_DEPTH+1)  CL occupancy
//  mf_count              out  $clog2(MF_DEPTH+1)  MF occupancy
//  underflow_err         out  1            sticky: retire seen while empty
// BEHAVIOUR
//  Reset: pointers, counts, valid bits, err = 0; empties=1; readies=1; head outputs 0; matches 0.
//  Per FIFO: wptr/rptr in 0..DEPTH-1, wrap DEPTH-1 -> 0 explicitly; no modulo on ptr width.
//  Count: +1 on alloc only, -1 on retire only, unchanged on both. empty=(count==0).
//  ready = (count!=DEPTH); no same-cycle pass-through when full, even if retire asserted.
//  Alloc while !ready: ignored, no state change. Retire while empty: ignored, err<=1 until reset.
//  Alloc and retire same cycle on a non-full, non-empty FIFO: both take effect.
//  Alloc and retire same cycle on empty FIFO: alloc takes effect, retire ignored, err set.
//  Head outputs combinational from rptr entry; 0 when empty. New entry visible next cycle.
//  Matches combinational over valid entries only; retiring entry still matches in its retire cycle.
//  flush: next cycle all valid=0, ptrs=0, counts=0; alloc/retire in flush cycle ignored; err kept.
//  Reset mid-operation: immediate async clear to reset values; no entry survives.
//  Entry storage (rdidx/rdwen/ql) not reset; only valid bits are.
// STRUCTURE
//  Shared defines (QPU_defines.v): RFIDX/QUBIT widths, default depths.
//  Sub-module qpu_oitf_fifo_ctrl #(DEPTH): ptrs, valid vector, count, ready/empty, err, flush;
//  instantiated twice. Payload arrays and match logic stay in top.
// TESTING
//  1 reset then idle -> empties=1, readies=1, counts=0, matches=0, underflow_err=0.
//  2 CL_DEPTH=3: alloc rd=5,6,7 -> dis_cl_ready=0, cl_count=3; 4th alloc ignored; retire order 5,6,7.
//  3 alloc rd=9 rdwen=1; dispatch rs1idx=9 rs1en=1 -> rs1 match=1; rs1en=0 -> 0; after retire -> 0.
//  4 MF: alloc ql=8'b0000_0010; disp ql=8'b0000_0110 qfren=1 -> qf match=1; ql=8'b1000_0000 -> 0.
//  5 count=2, alloc+retire same cycle -> count stays 2, ptrs wrap at DEPTH-1 -> 0, order preserved.
//  6 retire on empty -> underflow_err=1, sticky across flush; flush with 3 entries -> empty next cycle.

Source files
------------

// File: rtl/qpu_exu_oitf_gen_pkg.sv
// Shared constants and helpers for the outstanding-instruction tracker.
// Default widths/depths mirror the core-wide QPU defines; helpers size
// pointers and occupancy counters for arbitrary (non power-of-two) depths.
package qpu_exu_oitf_gen_pkg;

  localparam int QPU_RFIDX_REAL_WIDTH = 5;
  localparam int QPU_QUBIT_NUM        = 8;
  localparam int OITF_CL_DEPTH_DEF    = 4;
  localparam int OITF_MF_DEPTH_DEF    = 4;

  // Per-cycle FIFO operation, encoded as {alloc accepted, retire accepted}.
  typedef enum logic [1:0] {
    FIFO_HOLD = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int oitf_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer spans 0..depth-1; at least one bit.
  function automatic int oitf_ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/qpu_exu_oitf_gen_if.sv
// Dispatch / retire / hazard bundle between the EXU pipeline and the OITF.
// Latency: n/a (wires only).  Backpressure: dis_cl_ready / dis_mf_ready.
// master = EXU side (drives dispatch and retire), slave = tracker.
interface qpu_exu_oitf_gen_if
  import qpu_exu_oitf_gen_pkg::*;
#(
  parameter int CL_DEPTH  = OITF_CL_DEPTH_DEF,
  parameter int MF_DEPTH  = OITF_MF_DEPTH_DEF,
  parameter int RFIDX_W   = QPU_RFIDX_REAL_WIDTH,
  parameter int QUBIT_NUM = QPU_QUBIT_NUM
);
  localparam int CL_CNT_W = oitf_cnt_w(CL_DEPTH);
  localparam int MF_CNT_W = oitf_cnt_w(MF_DEPTH);

  // pipeline control
  logic                 flush;
  // classical long-pipe dispatch
  logic                 dis_cl_ena;
  logic                 dis_cl_ready;
  logic                 disp_i_rdwen;
  logic [RFIDX_W-1:0]   disp_i_rdidx;
  logic                 disp_i_rs1en;
  logic                 disp_i_rs2en;
  logic [RFIDX_W-1:0]   disp_i_rs1idx;
  logic [RFIDX_W-1:0]   disp_i_rs2idx;
  // measurement dispatch
  logic                 dis_qf_ena;
  logic                 dis_mf_ready;
  logic                 disp_i_qfren;
  logic [QUBIT_NUM-1:0] disp_i_ql;
  // retire
  logic                 ret_cl_ena;
  logic                 ret_qf_ena;
  logic [RFIDX_W-1:0]   ret_rdidx;
  logic                 ret_rdwen;
  logic [QUBIT_NUM-1:0] ret_mf;
  // hazards
  logic                 oitfrd_match_disprs1;
  logic                 oitfrd_match_disprs2;
  logic                 oitfrd_match_disprd;
  logic                 oitfqf_match_dispql;
  // status
  logic                 oitf_empty;
  logic                 moitf_empty;
  logic [CL_CNT_W-1:0]  cl_count;
  logic [MF_CNT_W-1:0]  mf_count;
  logic                 underflow_err;

  modport master (
    output flush, dis_cl_ena, disp_i_rdwen, disp_i_rdidx,
           disp_i_rs1en, disp_i_rs2en, disp_i_rs1idx, disp_i_rs2idx,
           dis_qf_ena, disp_i_qfren, disp_i_ql, ret_cl_ena, ret_qf_ena,
    input  dis_cl_ready, dis_mf_ready, ret_rdidx, ret_rdwen, ret_mf,
           oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd,
           oitfqf_match_dispql, oitf_empty, moitf_empty, cl_count, mf_count,
           underflow_err
  );

  modport slave (
    input  flush, dis_cl_ena, disp_i_rdwen, disp_i_rdidx,
           disp_i_rs1en, disp_i_rs2en, disp_i_rs1idx, disp_i_rs2idx,
           dis_qf_ena, disp_i_qfren, disp_i_ql, ret_cl_ena, ret_qf_ena,
    output dis_cl_ready, dis_mf_ready, ret_rdidx, ret_rdwen, ret_mf,
           oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd,
           oitfqf_match_dispql, oitf_empty, moitf_empty, cl_count, mf_count,
           underflow_err
  );

endinterface

// File: rtl/qpu_exu_oitf_gen_fifo_ctrl.sv
// Circular-FIFO bookkeeping: pointers, per-entry valid bits, occupancy, sticky underflow.
// Latency: alloc/retire/flush take effect on the next clk edge; ready/empty are from registers.
// Backpressure: ready=0 when full; alloc while full or during flush is dropped, never queued.
// Ports: clk, rst_n, flush, alloc, retire in; alloc_ok (write strobe for payload at wptr),
//        wptr, rptr, valid, count, ready, empty, err out.
module qpu_exu_oitf_gen_fifo_ctrl
  import qpu_exu_oitf_gen_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = oitf_ptr_w(DEPTH),
  localparam int CNT_W = oitf_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc,
  input  logic             retire,
  output logic             alloc_ok,
  output logic [PTR_W-1:0] wptr,
  output logic [PTR_W-1:0] rptr,
  output logic [DEPTH-1:0] valid,
  output logic [CNT_W-1:0] count,
  output logic             ready,
  output logic             empty,
  output logic             err
);

  logic     retire_ok;
  fifo_op_e op;

  // Explicit wrap so non power-of-two depths never index past DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Readiness is purely occupancy based: a retire in the same cycle does
  // not free a slot for a simultaneous alloc when full.
  assign ready     = (count != CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign alloc_ok  = alloc  & ready  & ~flush;
  assign retire_ok = retire & ~empty & ~flush;

  always_comb begin
    op = fifo_op_e'({alloc_ok, retire_ok});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= '0;
      count <= '0;
    end else begin
      // Non-full and non-empty implies wptr != rptr, so both updates are disjoint.
      if (alloc_ok) begin
        valid[wptr] <= 1'b1;
        wptr        <= ptr_inc(wptr);
      end
      if (retire_ok) begin
        valid[rptr] <= 1'b0;
        rptr        <= ptr_inc(rptr);
      end
      case (op)
        FIFO_PUSH: count <= count + CNT_W'(1);
        FIFO_POP:  count <= count - CNT_W'(1);
        default:   count <= count;
      endcase
    end
  end

  // Sticky until reset; flush deliberately leaves it alone so software can
  // still observe a protocol violation that preceded the flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (retire && empty) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/qpu_exu_oitf_gen.sv
// Outstanding-instruction tracker: CL FIFO of long-pipe rd writebacks, MF FIFO of qubit lists.
// Latency: allocs visible at head/matches next cycle; head, matches, ready are combinational reads.
// Backpressure: dis_cl_ready/dis_mf_ready low when the matching FIFO is full; allocs then dropped.
// Ports: clk, rst_n, oitf (slave modport): dispatch/retire/flush in; readies, retire heads,
//        RAW/WAW/qubit hazard matches, empties, counts, sticky underflow_err out.
module qpu_exu_oitf_gen
  import qpu_exu_oitf_gen_pkg::*;
#(
  parameter int CL_DEPTH  = OITF_CL_DEPTH_DEF,
  parameter int MF_DEPTH  = OITF_MF_DEPTH_DEF,
  parameter int RFIDX_W   = QPU_RFIDX_REAL_WIDTH,
  parameter int QUBIT_NUM = QPU_QUBIT_NUM
) (
  input logic                 clk,
  input logic                 rst_n,
  qpu_exu_oitf_gen_if.slave   oitf
);

  localparam int CL_PTR_W = oitf_ptr_w(CL_DEPTH);
  localparam int MF_PTR_W = oitf_ptr_w(MF_DEPTH);
  localparam int CL_CNT_W = oitf_cnt_w(CL_DEPTH);
  localparam int MF_CNT_W = oitf_cnt_w(MF_DEPTH);

  logic                cl_alloc_ok, mf_alloc_ok;
  logic [CL_PTR_W-1:0] cl_wptr, cl_rptr;
  logic [MF_PTR_W-1:0] mf_wptr, mf_rptr;
  logic [CL_DEPTH-1:0] cl_valid;
  logic [MF_DEPTH-1:0] mf_valid;
  logic [CL_CNT_W-1:0] cl_count;
  logic [MF_CNT_W-1:0] mf_count;
  logic                cl_ready, mf_ready, cl_empty, mf_empty, cl_err, mf_err;

  qpu_exu_oitf_gen_fifo_ctrl #(.DEPTH(CL_DEPTH)) u_cl_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (oitf.flush),
    .alloc    (oitf.dis_cl_ena),
    .retire   (oitf.ret_cl_ena),
    .alloc_ok (cl_alloc_ok),
    .wptr     (cl_wptr),
    .rptr     (cl_rptr),
    .valid    (cl_valid),
    .count    (cl_count),
    .ready    (cl_ready),
    .empty    (cl_empty),
    .err      (cl_err)
  );

  qpu_exu_oitf_gen_fifo_ctrl #(.DEPTH(MF_DEPTH)) u_mf_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (oitf.flush),
    .alloc    (oitf.dis_qf_ena),
    .retire   (oitf.ret_qf_ena),
    .alloc_ok (mf_alloc_ok),
    .wptr     (mf_wptr),
    .rptr     (mf_rptr),
    .valid    (mf_valid),
    .count    (mf_count),
    .ready    (mf_ready),
    .empty    (mf_empty),
    .err      (mf_err)
  );

  // Payload storage: not reset, every read is qualified by a valid bit or empty.
  logic [RFIDX_W-1:0]   cl_rdidx_q [CL_DEPTH];
  logic                 cl_rdwen_q [CL_DEPTH];
  logic [QUBIT_NUM-1:0] mf_ql_q    [MF_DEPTH];

  always_ff @(posedge clk) begin
    if (cl_alloc_ok) begin
      cl_rdidx_q[cl_wptr] <= oitf.disp_i_rdidx;
      cl_rdwen_q[cl_wptr] <= oitf.disp_i_rdwen;
    end
    if (mf_alloc_ok) begin
      mf_ql_q[mf_wptr] <= oitf.disp_i_ql;
    end
  end

  // Hazard search over valid entries only. A retiring entry is still valid
  // in its retire cycle, so it keeps matching until the edge clears it.
  logic                 rs1_hit, rs2_hit, rd_hit;
  logic [QUBIT_NUM-1:0] ql_union;

  always_comb begin
    rs1_hit  = 1'b0;
    rs2_hit  = 1'b0;
    rd_hit   = 1'b0;
    ql_union = '0;
    for (int i = 0; i < CL_DEPTH; i++) begin
      if (cl_valid[i] && cl_rdwen_q[i]) begin
        if (cl_rdidx_q[i] == oitf.disp_i_rs1idx) rs1_hit = 1'b1;
        if (cl_rdidx_q[i] == oitf.disp_i_rs2idx) rs2_hit = 1'b1;
        if (cl_rdidx_q[i] == oitf.disp_i_rdidx)  rd_hit  = 1'b1;
      end
    end
    for (int j = 0; j < MF_DEPTH; j++) begin
      if (mf_valid[j]) ql_union = ql_union | mf_ql_q[j];
    end
  end

  assign oitf.oitfrd_match_disprs1 = oitf.disp_i_rs1en & rs1_hit;
  assign oitf.oitfrd_match_disprs2 = oitf.disp_i_rs2en & rs2_hit;
  assign oitf.oitfrd_match_disprd  = oitf.disp_i_rdwen & rd_hit;
  assign oitf.oitfqf_match_dispql  = oitf.disp_i_qfren & (|(ql_union & oitf.disp_i_ql));

  // Retire heads read straight from rptr; forced to zero when empty.
  assign oitf.ret_rdidx = cl_empty ? '0   : cl_rdidx_q[cl_rptr];
  assign oitf.ret_rdwen = cl_empty ? 1'b0 : cl_rdwen_q[cl_rptr];
  assign oitf.ret_mf    = mf_empty ? '0   : mf_ql_q[mf_rptr];

  assign oitf.dis_cl_ready  = cl_ready;
  assign oitf.dis_mf_ready  = mf_ready;
  assign oitf.oitf_empty    = cl_empty;
  assign oitf.moitf_empty   = mf_empty;
  assign oitf.cl_count      = cl_count;
  assign oitf.mf_count      = mf_count;
  assign oitf.underflow_err = cl_err | mf_err;

endmodule

// File: tb/tb_qpu_exu_oitf_gen.sv
// Self-checking bench for qpu_exu_oitf_gen with CL_DEPTH=3, MF_DEPTH=4.
// A queue model per FIFO predicts heads, acceptance and the sticky error.
module tb_qpu_exu_oitf_gen;

  localparam int CLD = 3;
  localparam int MFD = 4;
  localparam int RW  = 5;
  localparam int QN  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qpu_exu_oitf_gen_if #(.CL_DEPTH(CLD), .MF_DEPTH(MFD), .RFIDX_W(RW), .QUBIT_NUM(QN)) oitf ();

  qpu_exu_oitf_gen #(.CL_DEPTH(CLD), .MF_DEPTH(MFD), .RFIDX_W(RW), .QUBIT_NUM(QN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .oitf  (oitf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic          rdwen;
    logic [RW-1:0] rdidx;
  } cl_ent_t;

  cl_ent_t       cl_q[$];
  logic [QN-1:0] mf_q[$];
  logic          exp_err;

  // Values sampled mid-cycle by drive_cycle, before the edge commits.
  logic [RW-1:0] obs_rd, exp_rd;
  logic          obs_rdwen, exp_rdwen;
  logic [QN-1:0] obs_ql, exp_ql;
  logic          obs_rs1;

  task automatic idle_inputs();
    oitf.flush = 0; oitf.dis_cl_ena = 0; oitf.disp_i_rdwen = 0; oitf.disp_i_rdidx = '0;
    oitf.disp_i_rs1en = 0; oitf.disp_i_rs2en = 0; oitf.disp_i_rs1idx = '0; oitf.disp_i_rs2idx = '0;
    oitf.dis_qf_ena = 0; oitf.disp_i_qfren = 0; oitf.disp_i_ql = '0;
    oitf.ret_cl_ena = 0; oitf.ret_qf_ena = 0;
  endtask

  // One clock of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic drive_cycle(input bit ca, input logic [RW-1:0] rd, input bit rw, input bit cr,
                             input bit qa, input logic [QN-1:0] ql, input bit qr, input bit fl);
    int cl_n, mf_n;
    oitf.flush = fl; oitf.dis_cl_ena = ca; oitf.disp_i_rdidx = rd; oitf.disp_i_rdwen = rw;
    oitf.ret_cl_ena = cr; oitf.dis_qf_ena = qa; oitf.disp_i_ql = ql; oitf.ret_qf_ena = qr;
    #2;
    obs_rd = oitf.ret_rdidx; obs_rdwen = oitf.ret_rdwen; obs_ql = oitf.ret_mf;
    obs_rs1 = oitf.oitfrd_match_disprs1;
    cl_n = cl_q.size(); mf_n = mf_q.size();
    exp_rd    = (cl_n > 0) ? cl_q[0].rdidx : '0;
    exp_rdwen = (cl_n > 0) ? cl_q[0].rdwen : 1'b0;
    exp_ql    = (mf_n > 0) ? mf_q[0] : '0;
    if ((cr && cl_n == 0) || (qr && mf_n == 0)) exp_err = 1'b1;
    if (fl) begin
      cl_q.delete(); mf_q.delete();
    end else begin
      if (cr && cl_n > 0) void'(cl_q.pop_front());
      if (ca && cl_n < CLD) cl_q.push_back({rw, rd});
      if (qr && mf_n > 0) void'(mf_q.pop_front());
      if (qa && mf_n < MFD) mf_q.push_back(ql);
    end
    @(posedge clk); #1;
    oitf.flush = 0; oitf.dis_cl_ena = 0; oitf.ret_cl_ena = 0;
    oitf.dis_qf_ena = 0; oitf.ret_qf_ena = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    exp_err = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({oitf.oitf_empty, oitf.moitf_empty, oitf.dis_cl_ready, oitf.dis_mf_ready} !== 4'b1111) begin
      n_bad++; $display("FAIL reset_flags: got %b want 1111",
        {oitf.oitf_empty, oitf.moitf_empty, oitf.dis_cl_ready, oitf.dis_mf_ready});
    end
    n_cmp++;
    if (oitf.cl_count !== 2'd0 || oitf.mf_count !== 3'd0) begin
      n_bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", oitf.cl_count, oitf.mf_count);
    end
    n_cmp++;
    if (oitf.underflow_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_err: got %b want 0", oitf.underflow_err);
    end
    n_cmp++;
    if (oitf.ret_rdidx !== 5'd0 || oitf.ret_rdwen !== 1'b0 || oitf.ret_mf !== 8'd0) begin
      n_bad++; $display("FAIL reset_heads: got %h/%b/%h want 0/0/0", oitf.ret_rdidx, oitf.ret_rdwen, oitf.ret_mf);
    end
    oitf.disp_i_rs1en = 1; oitf.disp_i_rs2en = 1; oitf.disp_i_rdwen = 1;
    oitf.disp_i_qfren = 1; oitf.disp_i_ql = 8'hff;
    #1;
    n_cmp++;
    if ({oitf.oitfrd_match_disprs1, oitf.oitfrd_match_disprs2, oitf.oitfrd_match_disprd,
         oitf.oitfqf_match_dispql} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_matches: got %b want 0000", {oitf.oitfrd_match_disprs1,
        oitf.oitfrd_match_disprs2, oitf.oitfrd_match_disprd, oitf.oitfqf_match_dispql});
    end
    idle_inputs();
  endtask

  task automatic test_cl_full();
    drive_cycle(1, 5'd5, 1, 0, 0, '0, 0, 0);
    drive_cycle(1, 5'd6, 1, 0, 0, '0, 0, 0);
    drive_cycle(1, 5'd7, 1, 0, 0, '0, 0, 0);
    n_cmp++;
    if (oitf.cl_count !== 2'd3 || oitf.dis_cl_ready !== 1'b0) begin
      n_bad++; $display("FAIL full_state: got cnt=%0d rdy=%b want 3/0", oitf.cl_count, oitf.dis_cl_ready);
    end
    drive_cycle(1, 5'd8, 1, 0, 0, '0, 0, 0);
    n_cmp++;
    if (oitf.cl_count !== 2'd3 || oitf.ret_rdidx !== 5'd5) begin
      n_bad++; $display("FAIL full_drop: got cnt=%0d head=%0d want 3/5", oitf.cl_count, oitf.ret_rdidx);
    end
    // Full: retire takes effect, simultaneous alloc must still be refused.
    drive_cycle(1, 5'd8, 1, 1, 0, '0, 0, 0);
    n_cmp++;
    if (obs_rd !== exp_rd) begin
      n_bad++; $display("FAIL full_retire_head: got %0d want %0d", obs_rd, exp_rd);
    end
    n_cmp++;
    if (oitf.cl_count !== 2'd2) begin
      n_bad++; $display("FAIL full_no_passthru: got cnt=%0d want 2", oitf.cl_count);
    end
    for (int k = 0; k < 2; k++) begin
      drive_cycle(0, '0, 0, 1, 0, '0, 0, 0);
      n_cmp++;
      if (obs_rd !== exp_rd || obs_rdwen !== exp_rdwen) begin
        n_bad++; $display("FAIL order_head%0d: got %0d/%b want %0d/%b", k, obs_rd, obs_rdwen, exp_rd, exp_rdwen);
      end
    end
    n_cmp++;
    if (oitf.oitf_empty !== 1'b1 || oitf.ret_rdidx !== 5'd0) begin
      n_bad++; $display("FAIL drained: got empty=%b head=%0d want 1/0", oitf.oitf_empty, oitf.ret_rdidx);
    end
  endtask

  task automatic test_rs_match();
    drive_cycle(1, 5'd9, 1, 0, 0, '0, 0, 0);
    oitf.disp_i_rs1en = 1; oitf.disp_i_rs1idx = 5'd9; #1;
    n_cmp++;
    if (oitf.oitfrd_match_disprs1 !== 1'b1) begin
      n_bad++; $display("FAIL rs1_hit: got %b want 1", oitf.oitfrd_match_disprs1);
    end
    oitf.disp_i_rs1en = 0; #1;
    n_cmp++;
    if (oitf.oitfrd_match_disprs1 !== 1'b0) begin
      n_bad++; $display("FAIL rs1_disabled: got %b want 0", oitf.oitfrd_match_disprs1);
    end
    oitf.disp_i_rs1en = 1; oitf.disp_i_rs1idx = 5'd10;
    oitf.disp_i_rs2en = 1; oitf.disp_i_rs2idx = 5'd9; #1;
    n_cmp++;
    if ({oitf.oitfrd_match_disprs1, oitf.oitfrd_match_disprs2} !== 2'b01) begin
      n_bad++; $display("FAIL rs_idx_sel: got %b want 01", {oitf.oitfrd_match_disprs1, oitf.oitfrd_match_disprs2});
    end
    oitf.disp_i_rdwen = 1; oitf.disp_i_rdidx = 5'd9; #1;
    n_cmp++;
    if (oitf.oitfrd_match_disprd !== 1'b1) begin
      n_bad++; $display("FAIL rd_waw: got %b want 1", oitf.oitfrd_match_disprd);
    end
    oitf.disp_i_rdwen = 0; #1;
    n_cmp++;
    if (oitf.oitfrd_match_disprd !== 1'b0) begin
      n_bad++; $display("FAIL rd_waw_off: got %b want 0", oitf.oitfrd_match_disprd);
    end
    oitf.disp_i_rs2en = 0;
    // Entry without rd write must never match.
    drive_cycle(1, 5'd12, 0, 0, 0, '0, 0, 0);
    oitf.disp_i_rs1idx = 5'd12; #1;
    n_cmp++;
    if (oitf.oitfrd_match_disprs1 !== 1'b0) begin
      n_bad++; $display("FAIL rs1_no_rdwen: got %b want 0", oitf.oitfrd_match_disprs1);
    end
    oitf.disp_i_rs1idx = 5'd9;
    drive_cycle(0, '0, 0, 1, 0, '0, 0, 0);
    n_cmp++;
    if (obs_rs1 !== 1'b1 || obs_rd !== exp_rd) begin
      n_bad++; $display("FAIL retire_cycle_match: got m=%b head=%0d want 1/%0d", obs_rs1, obs_rd, exp_rd);
    end
    #1;
    n_cmp++;
    if (oitf.oitfrd_match_disprs1 !== 1'b0) begin
      n_bad++; $display("FAIL rs1_after_retire: got %b want 0", oitf.oitfrd_match_disprs1);
    end
    drive_cycle(0, '0, 0, 1, 0, '0, 0, 0);
    n_cmp++;
    if (obs_rd !== exp_rd || obs_rdwen !== exp_rdwen) begin
      n_bad++; $display("FAIL head_rdwen0: got %0d/%b want %0d/%b", obs_rd, obs_rdwen, exp_rd, exp_rdwen);
    end
    idle_inputs();
  endtask

  task automatic test_mf_match();
    drive_cycle(0, '0, 0, 0, 1, 8'b0000_0010, 0, 0);
    oitf.disp_i_qfren = 1; oitf.disp_i_ql = 8'b0000_0110; #1;
    n_cmp++;
    if (oitf.oitfqf_match_dispql !== 1'b1) begin
      n_bad++; $display("FAIL qf_hit: got %b want 1", oitf.oitfqf_match_dispql);
    end
    oitf.disp_i_ql = 8'b1000_0000; #1;
    n_cmp++;
    if (oitf.oitfqf_match_dispql !== 1'b0) begin
      n_bad++; $display("FAIL qf_miss: got %b want 0", oitf.oitfqf_match_dispql);
    end
    oitf.disp_i_qfren = 0; oitf.disp_i_ql = 8'b0000_0110; #1;
    n_cmp++;
    if (oitf.oitfqf_match_dispql !== 1'b0) begin
      n_bad++; $display("FAIL qf_noqfren: got %b want 0", oitf.oitfqf_match_dispql);
    end
    drive_cycle(0, '0, 0, 0, 1, 8'b0100_0000, 0, 0);
    oitf.disp_i_qfren = 1; oitf.disp_i_ql = 8'b1100_0000; #1;
    n_cmp++;
    if (oitf.oitfqf_match_dispql !== 1'b1) begin
      n_bad++; $display("FAIL qf_second_entry: got %b want 1", oitf.oitfqf_match_dispql);
    end
    drive_cycle(0, '0, 0, 0, 0, 8'b0000_0110, 1, 0);
    n_cmp++;
    if (obs_ql !== exp_ql) begin
      n_bad++; $display("FAIL mf_head0: got %h want %h", obs_ql, exp_ql);
    end
    #1;
    n_cmp++;
    if (oitf.oitfqf_match_dispql !== 1'b0) begin
      n_bad++; $display("FAIL qf_after_retire: got %b want 0", oitf.oitfqf_match_dispql);
    end
    drive_cycle(0, '0, 0, 0, 0, '0, 1, 0);
    n_cmp++;
    if (obs_ql !== exp_ql || oitf.moitf_empty !== 1'b1) begin
      n_bad++; $display("FAIL mf_head1: got %h e=%b want %h e=1", obs_ql, oitf.moitf_empty, exp_ql);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    drive_cycle(1, 5'd1, 1, 0, 1, 8'h01, 0, 0);
    drive_cycle(1, 5'd2, 1, 0, 1, 8'h02, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, 5'(3 + i), 1, 1, 1, 8'(8'h10 + i), 1, 0);
      n_cmp++;
      if (obs_rd !== exp_rd || obs_ql !== exp_ql) begin
        n_bad++; $display("FAIL b2b_head%0d: got %0d/%h want %0d/%h", i, obs_rd, obs_ql, exp_rd, exp_ql);
      end
      n_cmp++;
      if (oitf.cl_count !== 2'd2 || oitf.mf_count !== 3'd2) begin
        n_bad++; $display("FAIL b2b_count%0d: got %0d/%0d want 2/2", i, oitf.cl_count, oitf.mf_count);
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive_cycle(0, '0, 0, 1, 0, '0, 1, 0);
      n_cmp++;
      if (obs_rd !== exp_rd || obs_ql !== exp_ql) begin
        n_bad++; $display("FAIL b2b_drain%0d: got %0d/%h want %0d/%h", k, obs_rd, obs_ql, exp_rd, exp_ql);
      end
    end
    n_cmp++;
    if ({oitf.oitf_empty, oitf.moitf_empty} !== 2'b11) begin
      n_bad++; $display("FAIL b2b_empty: got %b want 11", {oitf.oitf_empty, oitf.moitf_empty});
    end
  endtask

  task automatic test_underflow_flush();
    n_cmp++;
    if (oitf.underflow_err !== exp_err) begin
      n_bad++; $display("FAIL err_clean: got %b want %b", oitf.underflow_err, exp_err);
    end
    // Alloc and retire together on an empty MF: alloc lands, retire flags error.
    drive_cycle(0, '0, 0, 0, 1, 8'h81, 1, 0);
    n_cmp++;
    if (oitf.mf_count !== 3'd1 || oitf.underflow_err !== exp_err) begin
      n_bad++; $display("FAIL empty_alloc_retire: got cnt=%0d err=%b want 1/%b", oitf.mf_count, oitf.underflow_err, exp_err);
    end
    drive_cycle(0, '0, 0, 0, 0, '0, 1, 0);
    n_cmp++;
    if (obs_ql !== exp_ql) begin
      n_bad++; $display("FAIL uf_mf_head: got %h want %h", obs_ql, exp_ql);
    end
    drive_cycle(0, '0, 0, 1, 0, '0, 0, 0);
    drive_cycle(1, 5'd21, 1, 0, 1, 8'h05, 0, 0);
    drive_cycle(1, 5'd22, 1, 0, 0, '0, 0, 0);
    drive_cycle(1, 5'd23, 1, 0, 0, '0, 0, 0);
    n_cmp++;
    if (oitf.cl_count !== 2'd3 || oitf.underflow_err !== exp_err) begin
      n_bad++; $display("FAIL pre_flush: got cnt=%0d err=%b want 3/%b", oitf.cl_count, oitf.underflow_err, exp_err);
    end
    drive_cycle(1, 5'd24, 1, 1, 1, 8'h03, 1, 1);
    n_cmp++;
    if ({oitf.cl_count, oitf.mf_count} !== 5'd0 || {oitf.oitf_empty, oitf.moitf_empty,
         oitf.dis_cl_ready, oitf.dis_mf_ready} !== 4'b1111) begin
      n_bad++; $display("FAIL flush_clear: got cnt=%0d/%0d flags=%b want 0/0 1111", oitf.cl_count, oitf.mf_count,
        {oitf.oitf_empty, oitf.moitf_empty, oitf.dis_cl_ready, oitf.dis_mf_ready});
    end
    n_cmp++;
    if (oitf.underflow_err !== exp_err || oitf.ret_rdidx !== 5'd0) begin
      n_bad++; $display("FAIL flush_err_kept: got err=%b head=%0d want %b/0", oitf.underflow_err, oitf.ret_rdidx, exp_err);
    end
    drive_cycle(1, 5'd25, 1, 0, 0, '0, 0, 0);
    n_cmp++;
    if (oitf.ret_rdidx !== cl_q[0].rdidx || oitf.cl_count !== 2'd1) begin
      n_bad++; $display("FAIL post_flush_alloc: got %0d cnt=%0d want %0d/1", oitf.ret_rdidx, oitf.cl_count, cl_q[0].rdidx);
    end
    // Asynchronous reset mid-operation clears immediately, without a clock edge.
    rst_n = 1'b0;
    cl_q.delete(); mf_q.delete(); exp_err = 1'b0;
    #1;
    n_cmp++;
    if (oitf.cl_count !== 2'd0 || oitf.oitf_empty !== 1'b1 || oitf.underflow_err !== exp_err || oitf.ret_rdidx !== 5'd0) begin
      n_bad++; $display("FAIL async_reset: got cnt=%0d e=%b err=%b head=%0d want 0/1/0/0",
        oitf.cl_count, oitf.oitf_empty, oitf.underflow_err, oitf.ret_rdidx);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (oitf.cl_count !== 2'd0 || oitf.dis_cl_ready !== 1'b1) begin
      n_bad++; $display("FAIL post_reset: got cnt=%0d rdy=%b want 0/1", oitf.cl_count, oitf.dis_cl_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cl_full();
    test_rs_match();
    test_mf_match();
    test_back_to_back();
    test_underflow_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
